// File: rtl/event_wb_initiator.sv
// Event-driven Wishbone initiator: one command -> one bus cycle -> one response.
// Optional retry-on-rty support via EVENT_WB_INITIATOR_RETRY_EN.
module event_wb_initiator #(
    parameter int TIMEOUT   = 255,
    parameter int RETRY_MAX = 3
) (
    input  logic        wb_clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [12:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [12:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic [1:0]  rsp_status_o,
    output logic        busy_o,
    output logic [15:0] fail_count_o
);

    typedef enum logic [1:0] {IDLE, CYCLE, GAP, RESP} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] tmo_q, tmo_d;
    logic        we_lat_q, we_lat_d;
    logic [12:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]  rsp_status_q, rsp_status_d;
    logic [15:0] fail_q, fail_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic        rdy_q, rdy_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;

`ifdef EVENT_WB_INITIATOR_RETRY_EN
    logic [3:0]  retry_q, retry_d;
`else
    logic [3:0]  retry_max_unused;
    assign retry_max_unused = 4'(RETRY_MAX);
`endif

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        we_lat_d     = we_lat_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        fail_d       = fail_q;
`ifdef EVENT_WB_INITIATOR_RETRY_EN
        retry_d      = retry_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && rdy_q) begin
                    we_lat_d = cmd_we_i;
                    adr_d    = cmd_adr_i;
                    dat_d    = cmd_dat_i;
                    sel_d    = cmd_sel_i;
                    tmo_d    = 16'd0;
                    state_d  = CYCLE;
`ifdef EVENT_WB_INITIATOR_RETRY_EN
                    retry_d  = 4'd0;
`endif
                end
            end
            CYCLE: begin
                tmo_d = tmo_q + 16'd1;
                // Terminations outrank the timeout in the same cycle.
                if (wb_ack_i) begin
                    rsp_dat_d    = we_lat_q ? 32'd0 : wb_dat_i;
                    rsp_status_d = 2'b00;
                    state_d      = RESP;
                end else if (wb_err_i) begin
                    rsp_dat_d    = 32'd0;
                    rsp_status_d = 2'b01;
                    state_d      = RESP;
                end else if (wb_rty_i) begin
                    rsp_dat_d    = 32'd0;
                    rsp_status_d = 2'b10;
                    state_d      = RESP;
`ifdef EVENT_WB_INITIATOR_RETRY_EN
                    if (retry_q < 4'(RETRY_MAX)) begin
                        retry_d = retry_q + 4'd1;
                        state_d = GAP;
                    end
`endif
                end else if (tmo_q == TMO_LAST) begin
                    rsp_dat_d    = 32'hDEADDEAD;
                    rsp_status_d = 2'b11;
                    state_d      = RESP;
                end
            end
            GAP: begin
                tmo_d   = 16'd0;
                state_d = CYCLE;
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == RESP && state_q != RESP &&
            rsp_status_d != 2'b00 && fail_q != 16'hFFFF)
            fail_d = fail_q + 16'd1;

        cyc_d       = (state_d == CYCLE);
        we_d        = (state_d == CYCLE) && we_lat_d;
        rdy_d       = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            tmo_q        <= 16'd0;
            we_lat_q     <= 1'b0;
            adr_q        <= 13'd0;
            dat_q        <= 32'd0;
            sel_q        <= 4'd0;
            rsp_dat_q    <= 32'd0;
            rsp_status_q <= 2'b00;
            fail_q       <= 16'd0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            rdy_q        <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
`ifdef EVENT_WB_INITIATOR_RETRY_EN
            retry_q      <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            we_lat_q     <= we_lat_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            fail_q       <= fail_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            rdy_q        <= rdy_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
`ifdef EVENT_WB_INITIATOR_RETRY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    assign cmd_ready_o  = rdy_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = we_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign busy_o       = busy_q;
    assign fail_count_o = fail_q;

endmodule

// File: tb/tb_event_wb_initiator.sv
// Randomized + directed bench for event_wb_initiator against a transaction-level model.
module tb_event_wb_initiator;

    localparam int TMO  = 8;
    localparam int RMAX = 3;

    localparam int K_ACK    = 0;
    localparam int K_ERR    = 1;
    localparam int K_SILENT = 2;
    localparam int K_ACKERR = 3;
    localparam int K_RTY    = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_we_i = 1'b0;
    logic [12:0] cmd_adr_i = '0;
    logic [31:0] cmd_dat_i = '0;
    logic [3:0]  cmd_sel_i = '0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [12:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_rty_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic        busy_o;
    logic [15:0] fail_count_o;

    int checks = 0;
    int errors = 0;
    int model_fc = 0;
    int lat_a[8];

    event_wb_initiator #(.TIMEOUT(TMO), .RETRY_MAX(RMAX)) dut (
        .wb_clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i),
        .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
        .busy_o(busy_o), .fail_count_o(fail_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one command; the target answers attempt i after lat_a[i] cycles.
    task automatic run_txn(input logic we, input logic [12:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input logic [31:0] rdata, input int n_rty,
                           input int fin, input int k);
        int allowed, exec_n, exp_cyc, exp_gaps;
        logic [1:0]  exp_st;
        logic [31:0] exp_dat;
        int att, acyc, cyc_tot, gap_tot, fld_bad, unstable, kind;
        logic prev, done;
        logic [31:0] d0;
        logic [1:0]  s0;

`ifdef EVENT_WB_INITIATOR_RETRY_EN
        allowed = RMAX;
`else
        allowed = 0;
`endif
        if (n_rty > allowed) begin
            exec_n  = allowed + 1;
            exp_st  = 2'b10;
            exp_dat = 32'd0;
        end else begin
            exec_n = n_rty + 1;
            case (fin)
                K_ERR:    begin exp_st = 2'b01; exp_dat = 32'd0; end
                K_SILENT: begin exp_st = 2'b11; exp_dat = 32'hDEADDEAD; end
                default:  begin exp_st = 2'b00; exp_dat = we ? 32'd0 : rdata; end
            endcase
        end
        exp_gaps = exec_n - 1;
        exp_cyc = 0;
        for (int i = 0; i < exec_n - 1; i++) exp_cyc += lat_a[i];
        exp_cyc += (exp_st == 2'b11) ? TMO : lat_a[exec_n - 1];
        if (exp_st != 2'b00 && model_fc < 65535) model_fc++;

        chk("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
        wb_dat_i = rdata;
        @(negedge clk);
        cmd_valid_i = 1'b0;

        att = 0; acyc = 0; cyc_tot = 0; gap_tot = 0; fld_bad = 0;
        prev = 1'b0; done = 1'b0;
        for (int g = 0; g < 300 && !done; g++) begin
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
            if (rsp_valid_o) begin
                done = 1'b1;
            end else if (wb_cyc_o) begin
                if (!prev && cyc_tot > 0 && att < 7) begin
                    att++; acyc = 0;
                end
                acyc++; cyc_tot++;
                if (wb_stb_o !== 1'b1 || wb_we_o !== we || wb_adr_o !== adr ||
                    wb_dat_o !== dat || wb_sel_o !== sel || cmd_ready_o !== 1'b0)
                    fld_bad++;
                kind = (att < n_rty) ? K_RTY : fin;
                if (acyc == lat_a[att] && kind != K_SILENT) begin
                    wb_ack_i = (kind == K_ACK || kind == K_ACKERR);
                    wb_err_i = (kind == K_ERR || kind == K_ACKERR);
                    wb_rty_i = (kind == K_RTY);
                end
            end else begin
                if (busy_o) gap_tot++;
                if (wb_stb_o || wb_we_o) fld_bad++;
            end
            prev = wb_cyc_o;
            if (!done) @(negedge clk);
        end
        chk("resp_reached", {31'd0, done}, 32'd1);
        chk("status", {30'd0, rsp_status_o}, {30'd0, exp_st});
        chk("rsp_dat", rsp_dat_o, exp_dat);
        chk("cyc_cycles", cyc_tot, exp_cyc);
        chk("gap_cycles", gap_tot, exp_gaps);
        chk("fail_count", {16'd0, fail_count_o}, model_fc);
        chk("bus_fields", fld_bad, 0);

        d0 = rsp_dat_o; s0 = rsp_status_o; unstable = 0;
        for (int i = 0; i <= k; i++) begin
            if (i > 0) @(negedge clk);
            if (rsp_valid_o !== 1'b1 || rsp_dat_o !== d0 ||
                rsp_status_o !== s0 || cmd_ready_o !== 1'b0 || wb_cyc_o !== 1'b0)
                unstable++;
        end
        chk("resp_stable", unstable, 0);
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
        chk("post_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("post_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("post_busy", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready_o}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_fail", {16'd0, fail_count_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rel_ready", {31'd0, cmd_ready_o}, 32'd1);

        lat_a = '{default: 1};
        lat_a[0] = 2;
        run_txn(1'b1, 13'h000, 32'h00000F01, 4'hF, 32'h0, 0, K_ACK, 0);

        lat_a = '{default: 1};
        run_txn(1'b0, 13'h010, 32'h0, 4'hF, 32'h12345678, 0, K_ACK, 5);

        run_txn(1'b0, 13'h020, 32'h0, 4'h3, 32'h0, 0, K_SILENT, 1);

        lat_a = '{default: 1};
        run_txn(1'b0, 13'h030, 32'h0, 4'hF, 32'hA5A5A5A5, 2, K_ACK, 0);

        lat_a = '{default: 3};
        run_txn(1'b0, 13'h040, 32'h0, 4'hF, 32'h0BADF00D, 0, K_ACKERR, 0);

        lat_a = '{default: TMO};
        run_txn(1'b0, 13'h050, 32'h0, 4'hF, 32'hCAFEF00D, 0, K_ACK, 0);

        // Reset while the target stalls mid-cycle.
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 13'h1FF;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        chk("mid_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("mid_rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("mid_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
        rst_i = 1'b0;
        model_fc = 0;
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("mid_rst_fail", {16'd0, fail_count_o}, 32'd0);

        for (int t = 0; t < 40; t++) begin
            int nr;
            nr = ($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 5));
            for (int i = 0; i < 8; i++) lat_a[i] = int'($urandom_range(1, TMO));
            run_txn(1'($urandom), 13'($urandom), $urandom, 4'($urandom),
                    $urandom, nr, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
